// File: rtl/cnl_job_seq_pkg.sv
// Shared types and constants for the quad job sequencers.
package cnl_job_seq_pkg;

    localparam int unsigned C_JOB_PARAM_WIDTH = 128;
    localparam int unsigned C_CFG_WIDTH       = 128;
    localparam int unsigned C_DEFAULT_TIMEOUT = 1048576;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_START,
        S_WAIT_FREQ,
        S_FETCH,
        S_WAIT_DONE,
        S_CACK,
        S_ERR
    } job_seq_state_t;

endpackage

// File: rtl/cnl_watchdog_cnt.sv
// Cycle watchdog: counts enabled cycles since the last clear, flags expiry on the last allowed cycle.
module cnl_watchdog_cnt #(
    parameter int unsigned C_LIMIT = 1048576
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW = (C_LIMIT > 2) ? $clog2(C_LIMIT) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == CW'(C_LIMIT - 1));

endmodule

// File: rtl/cnl_quad_job_sequencer.sv
// Drives one quad through descriptor pop, config writes and the start/fetch/complete handshake.
module cnl_quad_job_sequencer
    import cnl_job_seq_pkg::*;
#(
    parameter int unsigned C_NUM_CFG_SLOTS  = 4,
    parameter int unsigned C_TIMEOUT_CYCLES = C_DEFAULT_TIMEOUT,
    parameter int unsigned C_JOB_CNT_WIDTH  = 16
) (
    input  logic                         clk_if,
    input  logic                         rst,
    input  logic                         desc_valid,
    output logic                         desc_ready,
    input  logic [C_JOB_PARAM_WIDTH-1:0] desc_params,
    input  logic [2:0]                   desc_cfg_cnt,
    input  logic                         cfg_in_valid,
    output logic                         cfg_in_ready,
    input  logic [C_CFG_WIDTH-1:0]       cfg_in_data,
    output logic [C_NUM_CFG_SLOTS-1:0]   config_valid,
    input  logic [C_NUM_CFG_SLOTS-1:0]   config_accept,
    output logic [C_CFG_WIDTH-1:0]       config_data,
    output logic                         job_start,
    input  logic                         job_accept,
    output logic [C_JOB_PARAM_WIDTH-1:0] job_parameters,
    input  logic                         job_fetch_request,
    output logic                         job_fetch_ack,
    input  logic                         job_fetch_complete,
    input  logic                         job_complete,
    output logic                         job_complete_ack,
    output logic                         fetch_go,
    output logic                         busy,
    output logic                         err,
    input  logic                         err_clear,
    output logic [C_JOB_CNT_WIDTH-1:0]   jobs_done
);

    localparam logic [2:0] CFG_MAX = 3'(C_NUM_CFG_SLOTS);

    job_seq_state_t               state_q, state_d;
    logic [C_JOB_PARAM_WIDTH-1:0] params_q, params_d;
    logic [C_CFG_WIDTH-1:0]       cfg_data_q, cfg_data_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic [2:0]                   idx_q, idx_d;
    logic                         pending_q, pending_d;
    logic                         fetch_ack_q, fetch_ack_d;
    logic                         desc_ready_q;
    logic [C_JOB_CNT_WIDTH-1:0]   jobs_q, jobs_d;

    logic [2:0]                 cnt_clamped;
    logic [C_NUM_CFG_SLOTS-1:0] slot_mask;
    logic                       accept_hit;
    logic                       wd_enable;
    logic                       wd_expire;

    assign cnt_clamped = (desc_cfg_cnt > CFG_MAX) ? CFG_MAX : desc_cfg_cnt;
    assign slot_mask   = C_NUM_CFG_SLOTS'(1) << idx_q;
    assign accept_hit  = |(config_accept & slot_mask);
    assign wd_enable   = state_q inside {S_CFG, S_START, S_WAIT_FREQ, S_FETCH, S_WAIT_DONE};

    cnl_watchdog_cnt #(
        .C_LIMIT (C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_if),
        .rst_ni   (rst),
        .clear_i  (state_d != state_q),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        params_d    = params_q;
        cfg_data_d  = cfg_data_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        fetch_ack_d = 1'b0;
        jobs_d      = jobs_q;

        unique case (state_q)
            S_IDLE: begin
                if (desc_valid && desc_ready_q) begin
                    params_d  = desc_params;
                    cnt_d     = cnt_clamped;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = (cnt_clamped != '0) ? S_CFG : S_START;
                end
            end
            S_CFG: begin
                if (pending_q) begin
                    if (accept_hit) begin
                        pending_d = 1'b0;
                        idx_d     = idx_q + 3'd1;
                        if ((idx_q + 3'd1) == cnt_q) begin
                            state_d = S_START;
                        end
                    end
                end else if (cfg_in_valid) begin
                    cfg_data_d = cfg_in_data;
                    pending_d  = 1'b1;
                end
            end
            S_START: begin
                if (job_accept) begin
                    state_d = S_WAIT_FREQ;
                end
            end
            S_WAIT_FREQ: begin
                if (job_fetch_request) begin
                    fetch_ack_d = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (job_fetch_complete) begin
                    state_d = job_complete ? S_CACK : S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (job_complete) begin
                    state_d = S_CACK;
                end
            end
            S_CACK: begin
                jobs_d  = jobs_q + 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (err_clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A handshake completing on the final allowed cycle wins over the timeout.
        if (wd_expire && (state_d == state_q)) begin
            state_d     = S_ERR;
            pending_d   = 1'b0;
            fetch_ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk_if) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            params_q     <= '0;
            cfg_data_q   <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            fetch_ack_q  <= 1'b0;
            desc_ready_q <= 1'b0;
            jobs_q       <= '0;
        end else begin
            state_q      <= state_d;
            params_q     <= params_d;
            cfg_data_q   <= cfg_data_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            fetch_ack_q  <= fetch_ack_d;
            desc_ready_q <= (state_d == S_IDLE);
            jobs_q       <= jobs_d;
        end
    end

    assign desc_ready       = desc_ready_q;
    assign cfg_in_ready     = (state_q == S_CFG) && !pending_q;
    assign config_valid     = ((state_q == S_CFG) && pending_q) ? slot_mask : '0;
    assign config_data      = cfg_data_q;
    assign job_start        = (state_q == S_START);
    assign job_parameters   = params_q;
    assign job_fetch_ack    = fetch_ack_q;
    assign fetch_go         = (state_q == S_FETCH);
    assign job_complete_ack = (state_q == S_CACK);
    assign busy             = (state_q != S_IDLE);
    assign err              = (state_q == S_ERR);
    assign jobs_done        = jobs_q;

endmodule

// File: tb/tb_cnl_quad_job_sequencer.sv
// Directed bench for cnl_quad_job_sequencer with a per-cycle reference model of the job protocol.
module tb_cnl_quad_job_sequencer;

    localparam int TIMEOUT = 20;
    localparam int CNTW    = 4;

    logic         clk_if = 1'b0;
    logic         rst;
    logic         desc_valid, desc_ready;
    logic [127:0] desc_params;
    logic [2:0]   desc_cfg_cnt;
    logic         cfg_in_valid, cfg_in_ready;
    logic [127:0] cfg_in_data;
    logic [3:0]   config_valid, config_accept;
    logic [127:0] config_data;
    logic         job_start, job_accept;
    logic [127:0] job_parameters;
    logic         job_fetch_request, job_fetch_ack, job_fetch_complete;
    logic         job_complete, job_complete_ack;
    logic         fetch_go, busy, err, err_clear;
    logic [CNTW-1:0] jobs_done;

    int checks   = 0;
    int failures = 0;

    cnl_quad_job_sequencer #(
        .C_NUM_CFG_SLOTS  (4),
        .C_TIMEOUT_CYCLES (TIMEOUT),
        .C_JOB_CNT_WIDTH  (CNTW)
    ) dut (
        .clk_if             (clk_if),
        .rst                (rst),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_params        (desc_params),
        .desc_cfg_cnt       (desc_cfg_cnt),
        .cfg_in_valid       (cfg_in_valid),
        .cfg_in_ready       (cfg_in_ready),
        .cfg_in_data        (cfg_in_data),
        .config_valid       (config_valid),
        .config_accept      (config_accept),
        .config_data        (config_data),
        .job_start          (job_start),
        .job_accept         (job_accept),
        .job_parameters     (job_parameters),
        .job_fetch_request  (job_fetch_request),
        .job_fetch_ack      (job_fetch_ack),
        .job_fetch_complete (job_fetch_complete),
        .job_complete       (job_complete),
        .job_complete_ack   (job_complete_ack),
        .fetch_go           (fetch_go),
        .busy               (busy),
        .err                (err),
        .err_clear          (err_clear),
        .jobs_done          (jobs_done)
    );

    always #5 clk_if = ~clk_if;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: job phases tracked with plain ints, timeout as an absolute deadline.
    localparam int P_IDLE = 0, P_CFG = 1, P_START = 2, P_FREQ = 3;
    localparam int P_FETCH = 4, P_DONE = 5, P_CACK = 6, P_ERR = 7;

    int           m_ph = P_IDLE, m_left = 0, m_slot = 0, m_jobs = 0;
    longint       cyc = 0, m_deadline = 0;
    bit           m_pend = 0, m_ready = 0, m_ack = 0, m_on = 0;
    logic [127:0] m_params = '0, m_cfgdata = '0;

    always @(posedge clk_if) begin
        int nph;
        cyc++;
        if (!rst) begin
            m_ph = P_IDLE; m_ready = 0; m_pend = 0; m_ack = 0;
            m_params = '0; m_cfgdata = '0; m_jobs = 0; m_on = 1;
        end else begin
            nph   = m_ph;
            m_ack = 0;
            case (m_ph)
                P_IDLE: if (desc_valid && m_ready) begin
                    m_params = desc_params;
                    m_left   = (desc_cfg_cnt > 3'd4) ? 4 : int'(desc_cfg_cnt);
                    m_slot   = 0;
                    m_pend   = 0;
                    nph      = (m_left > 0) ? P_CFG : P_START;
                end
                P_CFG: begin
                    if (m_pend) begin
                        if (config_accept[m_slot]) begin
                            m_pend = 0;
                            m_slot++;
                            if (m_slot == m_left) nph = P_START;
                        end
                    end else if (cfg_in_valid) begin
                        m_cfgdata = cfg_in_data;
                        m_pend    = 1;
                    end
                end
                P_START: if (job_accept) nph = P_FREQ;
                P_FREQ:  if (job_fetch_request) begin nph = P_FETCH; m_ack = 1; end
                P_FETCH: if (job_fetch_complete) nph = job_complete ? P_CACK : P_DONE;
                P_DONE:  if (job_complete) nph = P_CACK;
                P_CACK:  begin m_jobs = (m_jobs + 1) % (1 << CNTW); nph = P_IDLE; end
                P_ERR:   if (err_clear) nph = P_IDLE;
                default: nph = P_IDLE;
            endcase
            if (m_ph >= P_CFG && m_ph <= P_DONE && nph == m_ph && cyc >= m_deadline) begin
                nph    = P_ERR;
                m_pend = 0;
            end
            if (nph != m_ph) m_deadline = cyc + TIMEOUT;
            m_ph    = nph;
            m_ready = (nph == P_IDLE);
        end
    end

    always @(negedge clk_if) begin
        if (m_on) begin
            chk("busy",             busy,             m_ph != P_IDLE);
            chk("desc_ready",       desc_ready,       m_ready);
            chk("cfg_in_ready",     cfg_in_ready,     m_ph == P_CFG && !m_pend);
            chk("config_valid",     config_valid,     (m_ph == P_CFG && m_pend) ? (4'b0001 << m_slot) : 4'b0000);
            chk("config_data",      config_data,      m_cfgdata);
            chk("job_start",        job_start,        m_ph == P_START);
            chk("job_parameters",   job_parameters,   m_params);
            chk("job_fetch_ack",    job_fetch_ack,    m_ack);
            chk("fetch_go",         fetch_go,         m_ph == P_FETCH);
            chk("job_complete_ack", job_complete_ack, m_ph == P_CACK);
            chk("err",              err,              m_ph == P_ERR);
            chk("jobs_done",        jobs_done,        m_jobs);
        end
    end

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    task automatic send_desc(input logic [127:0] p, input logic [2:0] n);
        int w = 0;
        desc_valid   = 1'b1;
        desc_params  = p;
        desc_cfg_cnt = n;
        while (!desc_ready && w < 40) begin tick(); w++; end
        chk("desc_ready_wait", desc_ready, 1'b1);
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic feed_cfg(input logic [127:0] word, input int slot, input int dly, input bit wrong);
        int w = 0;
        logic [3:0] exp_mask;
        exp_mask     = 4'b0001 << slot;
        cfg_in_valid = 1'b1;
        cfg_in_data  = word;
        while (!cfg_in_ready && w < 40) begin tick(); w++; end
        chk("cfg_in_ready_wait", cfg_in_ready, 1'b1);
        tick();
        cfg_in_valid = 1'b0;
        cfg_in_data  = '0;
        chk("cfg_valid_onehot", config_valid, exp_mask);
        chk("cfg_data_word", config_data, word);
        chk("start_before_cfg_done", job_start, 1'b0);
        for (int d = 0; d < dly; d++) begin
            if (wrong && d == 0) config_accept = ~exp_mask;
            tick();
            config_accept = '0;
            chk("cfg_valid_hold", config_valid, exp_mask);
            chk("cfg_data_hold", config_data, word);
        end
        config_accept = exp_mask;
        tick();
        config_accept = '0;
    endtask

    task automatic quad_run(input int acc_dly, input int req_dly, input bit together, output int start_cycles);
        int w = 0;
        while (!job_start && w < 40) begin tick(); w++; end
        chk("job_start_rise", job_start, 1'b1);
        start_cycles = 0;
        for (int i = 0; i < acc_dly; i++) begin
            if (job_start) start_cycles++;
            tick();
        end
        if (job_start) start_cycles++;
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
        chk("job_start_drop", job_start, 1'b0);
        for (int i = 0; i < req_dly; i++) tick();
        job_fetch_request = 1'b1;
        tick();
        job_fetch_request = 1'b0;
        chk("fetch_ack_pulse", job_fetch_ack, 1'b1);
        chk("fetch_go_set", fetch_go, 1'b1);
        tick();
        chk("fetch_ack_width", job_fetch_ack, 1'b0);
        job_fetch_complete = 1'b1;
        job_complete       = together;
        tick();
        job_fetch_complete = 1'b0;
        job_complete       = 1'b0;
        if (!together) begin
            chk("fetch_go_clr", fetch_go, 1'b0);
            chk("cack_early", job_complete_ack, 1'b0);
            tick();
            job_complete = 1'b1;
            tick();
            job_complete = 1'b0;
        end
        chk("cack_pulse", job_complete_ack, 1'b1);
        tick();
        chk("cack_width", job_complete_ack, 1'b0);
        chk("turnaround_ready", desc_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int sc;
        int n;
        int dly[4] = '{0, 2, 5, 1};
        logic [127:0] pa;
        pa = {16{8'hA5}};
        rst = 1'b0; desc_valid = 0; desc_params = '0; desc_cfg_cnt = '0;
        cfg_in_valid = 0; cfg_in_data = '0; config_accept = '0;
        job_accept = 0; job_fetch_request = 0; job_fetch_complete = 0;
        job_complete = 0; err_clear = 0;
        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_desc_ready", desc_ready, 1'b0);
        rst = 1'b1;

        // Stray quad inputs and err_clear in IDLE must do nothing.
        job_complete = 1'b1; err_clear = 1'b1;
        tick();
        job_complete = 1'b0; err_clear = 1'b0;
        tick();

        // Basic job, no config words.
        send_desc(pa, 3'd0);
        quad_run(2, 4, 1'b0, sc);
        chk("start_high_cycles", sc, 3);
        chk("params_latched", job_parameters, pa);
        chk("jobs_after_first", jobs_done, 1);

        // Four config words with staggered accepts.
        send_desc(128'h1234, 3'd4);
        for (int k = 0; k < 4; k++) feed_cfg(128'(k + 1), k, dly[k], 1'b0);
        chk("start_after_cfg", job_start, 1'b1);
        quad_run(0, 1, 1'b1, sc);

        // Count clamped to four slots; wrong-bit accept during slot 1.
        send_desc(128'hBEEF, 3'd7);
        for (int k = 0; k < 4; k++) feed_cfg(128'h100 + 128'(k), k, (k == 1) ? 3 : 0, k == 1);
        cfg_in_valid = 1'b1; cfg_in_data = 128'hDEAD;
        tick();
        chk("no_fifth_word", cfg_in_ready, 1'b0);
        chk("clamp_data_kept", config_data, 128'h103);
        cfg_in_valid = 1'b0; cfg_in_data = '0;
        quad_run(1, 0, 1'b0, sc);
        chk("jobs_after_three", jobs_done, 3);

        // Watchdog: fetch request never arrives.
        send_desc(128'h5A5A, 3'd0);
        n = 0;
        while (!job_start && n < 40) begin tick(); n++; end
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
        err_clear  = 1'b1;
        n = 0;
        while (!err && n < 60) begin tick(); err_clear = 1'b0; n++; end
        chk("wd_cycles_in_wait", n, TIMEOUT);
        desc_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("err_busy", busy, 1'b1);
            chk("err_desc_ready", desc_ready, 1'b0);
            chk("err_sticky", err, 1'b1);
        end
        desc_valid = 1'b0;
        err_clear  = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", err, 1'b0);
        chk("err_to_idle", busy, 1'b0);
        chk("jobs_after_err", jobs_done, 3);

        // Reset while in FETCH.
        send_desc(128'hC0DE, 3'd0);
        job_accept = 1'b1; tick(); job_accept = 1'b0;
        job_fetch_request = 1'b1; tick(); job_fetch_request = 1'b0;
        tick();
        chk("pre_reset_fetch_go", fetch_go, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_fetch_go", fetch_go, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_desc_ready", desc_ready, 1'b0);
        chk("rst_fetch_ack", job_fetch_ack, 1'b0);
        chk("rst_params", job_parameters, 128'h0);
        chk("rst_jobs", jobs_done, 0);
        tick();
        chk("post_rst_ready", desc_ready, 1'b1);
        send_desc(128'hF00D, 3'd0);
        quad_run(0, 0, 1'b1, sc);
        chk("jobs_after_rst_job", jobs_done, 1);

        // Back-to-back jobs until the counter wraps.
        for (int j = 0; j < 16; j++) begin
            send_desc(128'(j) << 64, 3'(j % 2));
            if (j % 2 == 1) feed_cfg(128'h900 + 128'(j), 0, 0, 1'b0);
            quad_run(0, 0, j % 3 == 0, sc);
        end
        chk("jobs_wrap", jobs_done, 1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnl_quad_job_sequencer.md
Name: cnl_quad_job_sequencer

Overview:
- Sequences one `cnn_layer_accel_quad` through a complete job on the `clk_if` domain.
- Pops a job descriptor and its config words from host-side valid/ready streams.
- Writes config words on `config_valid`/`config_accept`, then runs the quad's job handshake: start/accept, fetch request/ack/complete, complete/ack.
- Provides a per-job watchdog, a sticky error flag and a completed-job counter. Pixel and weight streaming stay outside this block.

Parameters:
- C_NUM_CFG_SLOTS, 4, number of config slots; matches the width of `config_valid`.
- C_TIMEOUT_CYCLES, 1048576, maximum cycles spent in any wait state before an error is raised.
- C_JOB_CNT_WIDTH, 16, width of the completed-job counter.

Ports:
- clk_if  input  1  interface clock; the only clock.
- rst  input  1  synchronous, active-low reset; 0 = reset, sampled on `clk_if` rising edge.
- desc_valid  input  1  job descriptor valid.
- desc_ready  output  1  job descriptor accepted.
- desc_params  input  128  job_parameters payload.
- desc_cfg_cnt  input  3  number of config words to send, 0..C_NUM_CFG_SLOTS.
- cfg_in_valid  input  1  config word valid.
- cfg_in_ready  output  1  config word taken.
- cfg_in_data  input  128  config word.
- config_valid  output  C_NUM_CFG_SLOTS  one-hot; bit k writes config slot k.
- config_accept  input  C_NUM_CFG_SLOTS  per-slot accept from the quad.
- config_data  output  128  config word to the quad.
- job_start  output  1  to quad.
- job_accept  input  1  from quad.
- job_parameters  output  128  to quad.
- job_fetch_request  input  1  from quad.
- job_fetch_ack  output  1  to quad.
- job_fetch_complete  input  1  from quad.
- job_complete  input  1  from quad.
- job_complete_ack  output  1  to quad.
- fetch_go  output  1  level; tells the external pixel/weight feeders to stream.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  sticky watchdog error.
- err_clear  input  1  clears `err` and returns the block to IDLE.
- jobs_done  output  C_JOB_CNT_WIDTH  completed-job counter; wraps.

Behaviour:
- Reset (rst=0): state=IDLE; all outputs 0, `job_parameters`/`config_data`=0, `jobs_done`=0, watchdog=0. Reset mid-job abandons the job immediately; no acks are emitted.
- States: IDLE, CFG, START, WAIT_FREQ, FETCH, WAIT_DONE, CACK, ERR.
- IDLE:
  - `desc_ready`=1.
  - On `desc_valid`: latch params into `job_parameters`, latch cfg_cnt, set slot index=0.
  - Go to CFG if cfg_cnt>0, else START.
  - cfg_cnt values above C_NUM_CFG_SLOTS are clamped to C_NUM_CFG_SLOTS.
- CFG:
  - `cfg_in_ready`=1 only while no config word is pending.
  - On `cfg_in_valid`&&`cfg_in_ready`: register the word into `config_data` and assert `config_valid[idx]` next cycle.
  - Hold both until `config_accept[idx]`=1. On that cycle deassert, increment idx.
  - After the last word go to START.
  - `config_data` and `config_valid` stay stable while unaccepted.
  - Accepts on bits other than idx are ignored.
- START:
  - `job_start`=1 with `job_parameters` held stable.
  - On `job_accept`: drop `job_start` the next cycle, go to WAIT_FREQ.
  - `job_start` is a level, not a pulse.
- WAIT_FREQ: on `job_fetch_request`, pulse `job_fetch_ack` for exactly 1 cycle, set `fetch_go`=1, go to FETCH.
- FETCH: on `job_fetch_complete`, set `fetch_go`=0, go to WAIT_DONE.
- WAIT_DONE:
  - On `job_complete`, go to CACK.
  - If `job_fetch_complete` and `job_complete` are seen high together in FETCH, go directly to CACK.
- CACK:
  - `job_complete_ack`=1 for 1 cycle, `jobs_done` += 1 (mod 2^C_JOB_CNT_WIDTH), then IDLE.
  - A new descriptor can be accepted on the cycle after CACK; the minimum turnaround is 1 idle cycle.
- Watchdog:
  - Counter clears on every state transition and increments in CFG, START, WAIT_FREQ, FETCH and WAIT_DONE.
  - At C_TIMEOUT_CYCLES-1: go to ERR, `err`=1, drop all quad-side strobes and `fetch_go`.
- ERR:
  - `busy`=1, `desc_ready`=0.
  - Stays until `err_clear`=1, then goes to IDLE with `err`=0 on the next cycle.
  - `err_clear` outside ERR has no effect.
- Latencies (registered outputs):
  - desc handshake to `job_start`: 1 cycle when cfg_cnt=0.
  - `job_fetch_request` to `job_fetch_ack`: 1 cycle.
  - `job_complete` to `job_complete_ack`: 1 cycle.
- Quad inputs that arrive outside their expected state (e.g. a stray `job_complete` in IDLE) are ignored.

Decomposition:
- Shared package `cnl_job_seq_pkg`: state enum `job_seq_state_t`, `C_JOB_PARAM_WIDTH`=128, `C_CFG_WIDTH`=128, default timeout constant.
- One sub-module: `cnl_watchdog_cnt`. It takes clear/enable inputs and produces an expiry pulse, and is reusable by the other quad controllers.

Test Plan:
- Basic job, cfg_cnt=0: descriptor params=128'hA5…; quad accepts after 3 cycles and requests fetch after 5 → `job_start` high 3 cycles with params stable; `job_fetch_ack` is a 1-cycle pulse 1 cycle after the request; `job_complete_ack` 1 cycle after `job_complete`; `jobs_done`=1.
- Config path, cfg_cnt=4 with words 1,2,3,4: `config_accept` delayed 0/2/5/1 cycles → `config_valid` = 0001, 0010, 0100, 1000 in order; each word held until accept; `job_start` only after the 4th accept.
- Clamp and stray accept, cfg_cnt=7: exactly 4 words consumed; an accept on the wrong bit during slot 1 leaves `config_valid`=0010 unchanged.
- Watchdog, C_TIMEOUT_CYCLES=16: quad never asserts `job_fetch_request` → `err`=1 at cycle 16 of WAIT_FREQ; `busy`=1 and `desc_ready`=0 until `err_clear`; IDLE afterwards.
- Reset mid-FETCH with rst=0 for 1 cycle: all outputs 0 next cycle, `jobs_done`=0; a fresh job afterwards completes normally.
- Back-to-back jobs: 65537 jobs with C_JOB_CNT_WIDTH=16 → `jobs_done` wraps to 1; a simultaneous `job_fetch_complete`+`job_complete` in FETCH goes straight to CACK.
